alu16_sequencer: RTL
====================

Name: alu16_sequencer

Overview:
- Initiator side of the alu16 datapath interface.
- Accepts one operation request at a time over a valid/ready handshake and drives the combinational alu16 operand, function and flag-in lines.
- Holds a per-function execution latency (MUL/DIV/MOD are multi-cycle budgets), traps divide-by-zero, and owns the architectural 6-bit flags register.
- Returns the result and flags over a valid/ready response handshake; sits between the instruction decode stage and writeback.

Parameters:
- CONTROL_ALU, 5, width of the function code (matches alu16 control_alu).
- MUL_CYCLES, 4, EXEC cycles budgeted for func 2 (range 1..15).
- DIV_CYCLES, 8, EXEC cycles budgeted for func 3 and 4 (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_func  in  CONTROL_ALU  op code: 0 ADD .. 15 ASR, 16 NOP, 17 CMP.
- req_a  in  16  operand a.
- req_b  in  16  operand b.
- req_use_carry  in  1  1: alu_flagsin = flags_q; 0: alu_flagsin = flags_q with bit 3 forced to 0.
- alu_a  out  16  to alu16 a.
- alu_b  out  16  to alu16 b.
- alu_func  out  CONTROL_ALU  to alu16 func.
- alu_flagsin  out  6  to alu16 flagsin.
- alu_y  in  16  from alu16 y.
- alu_flagsout  in  6  from alu16 flagsout.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  16  result.
- rsp_flags  out  6  flags produced by this op.
- rsp_err  out  2  bit0 divide-by-zero, bit1 illegal func.
- flags_q  out  6  architectural flags: [5]ZF [4]CO [3]CI/shift-out [2]PF [1]GF [0]LF.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - State IDLE.
  - req_ready=1, rsp_valid=0.
  - rsp_y=0, rsp_flags=0, rsp_err=0, flags_q=0.
  - alu_a/alu_b/alu_func/alu_flagsin driven from operand registers, which reset to 0.
  - busy=0.
- Reset mid-operation aborts the op: no response is issued and flags_q clears.
- IDLE: req_ready=1. On req_valid, latch func, a, b and use_carry into operand registers, then branch:
  - func>17: go to RESP with rsp_y=0, rsp_flags=0, rsp_err=2'b10; flags_q unchanged.
  - func 3 or 4 with b==0: go to RESP with rsp_y=16'hFFFF, rsp_flags=flags_q, rsp_err=2'b01; flags_q unchanged. alu16 is never evaluated.
  - Otherwise: load cnt = 1, MUL_CYCLES or DIV_CYCLES according to func, then go to EXEC.
- EXEC:
  - alu_* lines are driven from the operand registers, stable for the whole state.
  - Each cycle cnt decrements. On the cycle cnt==1, capture rsp_y=alu_y, rsp_flags=alu_flagsout and rsp_err=0, then go to RESP.
  - In that same capture cycle, flags_q<=alu_flagsout, except for func 16 (NOP), where flags_q is retained.
  - Latency from request accept to rsp_valid is 1+cnt cycles (ADD: 2).
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready, then return to IDLE.
  - req_ready=0 in EXEC and RESP; no request overlaps a response handshake.
  - Maximum throughput is one op per 3 cycles.
- Width rules: the sequencer performs no arithmetic on data. The carry/overflow meaning of flags comes solely from alu16.
- The counter is 4 bits wide; a zero cycle parameter is illegal and is asserted at elaboration.
- req inputs are ignored outside IDLE.

Decomposition:
- Shared package alu16_pkg:
  - alu_op_e enum: ADD=0, SUB, MUL, DIV, MOD, MVN, OR, AND, ORN, ANDN, EOR, EON, REV, LSL, LSR, ASR, NOP, CMP=17.
  - Flag bit index constants: ZF=5, CO=4, CI=3, PF=2, GF=1, LF=0.
  - seq_state_e: IDLE, EXEC, RESP.
  - Error bit constants.
- Single file with one FSM. The bench instantiates alu16 beside it; no extra sub-module.

Test Plan:
- ADD a=0x0001 b=0x0002, use_carry=0 -> rsp_valid 2 cycles after accept, rsp_y=0x0003, rsp_flags[4]=0, rsp_err=0.
- ADD a=0xFFFF b=0x0001 -> rsp_y=0x0000, flags_q[4]=1; then SUB 5-3 with use_carry=1 and flags_q[3]=0 -> rsp_y=0x0002.
- MUL a=0x0100 b=0x0100, MUL_CYCLES=4 -> rsp_valid exactly 5 cycles after accept, rsp_y=0x0000, rsp_flags[4]=1; busy high throughout.
- DIV a=0x1234 b=0x0000 -> rsp_valid 1 cycle after accept, rsp_y=0xFFFF, rsp_err=2'b01, flags_q unchanged. Func 20 -> rsp_err=2'b10, rsp_y=0.
- CMP a=5 b=3 with rsp_ready held low 3 cycles -> rsp_flags=6'b000010, rsp_* stable and req_ready=0 until handshake; IDLE on the next cycle.
- Assert reset in the 3rd EXEC cycle of DIV 100/7 -> next cycle IDLE, rsp_valid=0, flags_q=0, no response ever issued.

Source files
------------

// File: rtl/alu16_pkg.sv
// Shared definitions for the alu16 datapath: function codes, flag bit positions,
// sequencer states and response error bits.
package alu16_pkg;

  typedef enum logic [4:0] {
    ADD = 5'd0, SUB, MUL, DIV, MOD, MVN, OR, AND, ORN, ANDN,
    EOR, EON, REV, LSL, LSR, ASR, NOP, CMP
  } alu_op_e;

  localparam int unsigned ZF = 5;
  localparam int unsigned CO = 4;
  localparam int unsigned CI = 3;
  localparam int unsigned PF = 2;
  localparam int unsigned GF = 1;
  localparam int unsigned LF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

endpackage

// File: rtl/alu16_sequencer.sv
// Request/response sequencer driving a combinational alu16: per-function
// latency budget, divide-by-zero trap and the architectural flags register.
module alu16_sequencer
  import alu16_pkg::*;
#(
  parameter int unsigned CONTROL_ALU = 5,
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned DIV_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CONTROL_ALU-1:0] req_func,
  input  logic [15:0]            req_a,
  input  logic [15:0]            req_b,
  input  logic                   req_use_carry,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [CONTROL_ALU-1:0] alu_func,
  output logic [5:0]             alu_flagsin,
  input  logic [15:0]            alu_y,
  input  logic [5:0]             alu_flagsout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_y,
  output logic [5:0]             rsp_flags,
  output logic [1:0]             rsp_err,
  output logic [5:0]             flags_q,
  output logic                   busy
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("alu16_sequencer: MUL_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
    $error("alu16_sequencer: DIV_CYCLES must be in 1..15");
  end

  seq_state_e             state;
  logic [CONTROL_ALU-1:0] op_func;
  logic [15:0]            op_a;
  logic [15:0]            op_b;
  logic                   op_use_carry;
  logic [3:0]             cnt;
  logic [3:0]             lat_sel;
  logic                   req_illegal;
  logic                   req_div0;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_func    = op_func;
  // Without use_carry the carry-in seen by alu16 is forced low.
  assign alu_flagsin = op_use_carry ? flags_q : (flags_q & ~(6'b1 << CI));

  assign req_illegal = (req_func > CONTROL_ALU'(CMP));
  assign req_div0    = ((req_func == CONTROL_ALU'(DIV)) || (req_func == CONTROL_ALU'(MOD)))
                       && (req_b == '0);

  always_comb begin
    lat_sel = 4'd1;
    if (req_func == CONTROL_ALU'(MUL)) begin
      lat_sel = 4'(MUL_CYCLES);
    end else if ((req_func == CONTROL_ALU'(DIV)) || (req_func == CONTROL_ALU'(MOD))) begin
      lat_sel = 4'(DIV_CYCLES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_func      <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_use_carry <= 1'b0;
      cnt          <= '0;
      rsp_y        <= '0;
      rsp_flags    <= '0;
      rsp_err      <= '0;
      flags_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_func      <= req_func;
            op_a         <= req_a;
            op_b         <= req_b;
            op_use_carry <= req_use_carry;
            if (req_illegal) begin
              rsp_y     <= '0;
              rsp_flags <= '0;
              rsp_err   <= ERR_ILLEGAL;
              state     <= RESP;
            end else if (req_div0) begin
              rsp_y     <= '1;
              rsp_flags <= flags_q;
              rsp_err   <= ERR_DIV0;
              state     <= RESP;
            end else begin
              cnt   <= lat_sel;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rsp_y     <= alu_y;
            rsp_flags <= alu_flagsout;
            rsp_err   <= ERR_NONE;
            if (op_func != CONTROL_ALU'(NOP)) begin
              flags_q <= alu_flagsout;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
